// File: rtl/flash_byte_cache_if.sv
// Bus bundle for flash_byte_cache: upstream byte-read port, invalidate pulse,
// flash word-reader port and busy status.
// master: the environment side (cartridge bus plus flash reader).
// slave:  the cache itself.
interface flash_byte_cache_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic [7:0]            req_rdata;
    logic                  inv;
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_addr, inv, mem_ready, mem_rdata,
        input  req_ready, req_rdata, mem_valid, mem_addr, busy
    );

    modport slave (
        input  req_valid, req_addr, inv, mem_ready, mem_rdata,
        output req_ready, req_rdata, mem_valid, mem_addr, busy
    );
endinterface

// File: rtl/flash_byte_cache.sv
// flash_byte_cache: direct-mapped cache of 32-bit flash words serving
// single-byte reads. Misses fetch one word from the SPI flash reader.
// Optional sequential prefetch of the next word after each miss is enabled
// by defining FLASH_CACHE_PREFETCH_EN.
module flash_byte_cache #(
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    LINES      = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 24'h100000
) (
    input  logic               clk,
    input  logic               rst,
    flash_byte_cache_if.slave  bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RESP
`ifdef FLASH_CACHE_PREFETCH_EN
        , S_PREFETCH
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [31:0]           data_q [LINES];
    logic                  inv_pend_q, inv_pend_d;
    logic [WA_W-1:0]       waddr_q, waddr_d;
    logic [1:0]            off_q, off_d;
    logic [7:0]            rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;

    logic [IDX_W-1:0]      lk_idx, fill_idx, wr_idx;
    logic [TAG_W-1:0]      lk_tag, fill_tag, wr_tag;
    logic                  lk_hit, fill_en, mem_valid;

`ifdef FLASH_CACHE_PREFETCH_EN
    logic                  miss_q, miss_d;
    logic [WA_W-1:0]       pf_waddr;
    logic [IDX_W-1:0]      pf_idx;
    logic [TAG_W-1:0]      pf_tag;
    logic                  pf_hit;
`endif

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] o);
        return w[{o, 3'b000} +: 8];
    endfunction

    assign lk_idx   = bus.req_addr[2 +: IDX_W];
    assign lk_tag   = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign fill_idx = waddr_q[IDX_W-1:0];
    assign fill_tag = waddr_q[WA_W-1 -: TAG_W];

`ifdef FLASH_CACHE_PREFETCH_EN
    // Next sequential word; its index is the demand index + 1 modulo LINES.
    assign pf_waddr  = waddr_q + WA_W'(1);
    assign pf_idx    = pf_waddr[IDX_W-1:0];
    assign pf_tag    = pf_waddr[WA_W-1 -: TAG_W];
    assign pf_hit    = valid_q[pf_idx] && (tag_q[pf_idx] == pf_tag);
    assign mem_valid = (state_q == S_FETCH) || ((state_q == S_PREFETCH) && !pf_hit);
`else
    assign mem_valid = (state_q == S_FETCH);
`endif

    assign bus.mem_valid = mem_valid;
    assign bus.mem_addr  = maddr_q;
    assign bus.req_ready = (state_q == S_RESP);
    assign bus.req_rdata = rdata_q;
    assign bus.busy      = (state_q != S_IDLE);

    // Next-state logic: lookup, fetch/fill, response and optional prefetch.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        inv_pend_d = inv_pend_q | bus.inv;
        waddr_d    = waddr_q;
        off_d      = off_q;
        rdata_d    = rdata_q;
        maddr_d    = maddr_q;
        fill_en    = 1'b0;
        wr_idx     = fill_idx;
        wr_tag     = fill_tag;
`ifdef FLASH_CACHE_PREFETCH_EN
        miss_d     = miss_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (inv_pend_q) begin
                    // Invalidate takes the whole cycle; a waiting request is looked up next cycle.
                    valid_d    = '0;
                    inv_pend_d = bus.inv;
                end else if (bus.req_valid) begin
                    waddr_d = bus.req_addr[ADDR_WIDTH-1:2];
                    off_d   = bus.req_addr[1:0];
                    if (lk_hit) begin
                        rdata_d = byte_sel(data_q[lk_idx], bus.req_addr[1:0]);
                        state_d = S_RESP;
`ifdef FLASH_CACHE_PREFETCH_EN
                        miss_d  = 1'b0;
`endif
                    end else begin
                        maddr_d = BASE_ADDR + {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        state_d = S_FETCH;
`ifdef FLASH_CACHE_PREFETCH_EN
                        miss_d  = 1'b1;
`endif
                    end
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    fill_en = 1'b1;
                    rdata_d = byte_sel(bus.mem_rdata, off_q);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef FLASH_CACHE_PREFETCH_EN
                if (miss_q) begin
                    maddr_d = maddr_q + ADDR_WIDTH'(4);
                    state_d = S_PREFETCH;
                end
`endif
            end
`ifdef FLASH_CACHE_PREFETCH_EN
            S_PREFETCH: begin
                if (pf_hit) begin
                    state_d = S_IDLE;
                end else if (bus.mem_ready) begin
                    fill_en = 1'b1;
                    wr_idx  = pf_idx;
                    wr_tag  = pf_tag;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (fill_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
            rdata_q    <= 8'h00;
            maddr_q    <= '0;
`ifdef FLASH_CACHE_PREFETCH_EN
            miss_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            inv_pend_q <= inv_pend_d;
            rdata_q    <= rdata_d;
            maddr_q    <= maddr_d;
`ifdef FLASH_CACHE_PREFETCH_EN
            miss_q     <= miss_d;
`endif
        end
    end

    // Line storage and request address capture; meaningful only under valid bits / FSM state.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        off_q   <= off_d;
        if (fill_en) begin
            data_q[wr_idx] <= bus.mem_rdata;
            tag_q[wr_idx]  <= wr_tag;
        end
    end
endmodule

// File: tb/tb_flash_byte_cache.sv
// Self-checking bench for flash_byte_cache: expected bytes are queued when a
// read is driven and popped when req_ready returns. A behavioural flash
// reader answers word requests after a programmable number of wait cycles.
module tb_flash_byte_cache;
    localparam logic [23:0] BASE = 24'h100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_byte_cache_if #(.ADDR_WIDTH(24)) bus ();

    flash_byte_cache #(
        .ADDR_WIDTH (24),
        .LINES      (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  sb_q[$];
    logic [23:0] mem_log[$];
    int          mem_wait = 0;
    int          mem_cnt = 0;
    int          wcnt = 0;

    function automatic logic [31:0] mem_model(input logic [23:0] a);
        if (a == 24'h100000) return 32'hDDCCBBAA;
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'h3C, a[7:0] + 8'h11, a[7:0] ^ 8'hC3};
    endfunction

    // Flash reader model: accept after mem_wait cycles of mem_valid, one-cycle mem_ready.
    always @(negedge clk) begin
        if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
        end else if (bus.mem_valid) begin
            if (wcnt >= mem_wait) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_model(bus.mem_addr);
                mem_cnt++;
                mem_log.push_back(bus.mem_addr);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one read (called at a negedge); queue the expected byte, wait for req_ready.
    task automatic do_read(input logic [23:0] a, output logic [7:0] got,
                           output int lat, output int nmem);
        logic [31:0] w;
        logic [23:0] fa;
        int          m0;
        fa = BASE + {a[23:2], 2'b00};
        w  = mem_model(fa);
        sb_q.push_back(w[{a[1:0], 3'b000} +: 8]);
        m0  = mem_cnt;
        lat = -1;
        got = 8'hxx;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                lat = i;
                got = bus.req_rdata;
                break;
            end
        end
        bus.req_valid = 1'b0;
        nmem = mem_cnt - m0;
    endtask

    task automatic test_reset();
        n_total++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else n_pass++;
        n_total++; if (bus.req_rdata !== 8'h00) $display("FAIL reset_req_rdata: got %h want 00", bus.req_rdata); else n_pass++;
        n_total++; if (bus.mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid); else n_pass++;
        n_total++; if (bus.mem_addr !== 24'h0) $display("FAIL reset_mem_addr: got %h want 000000", bus.mem_addr); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_miss_fill();
        logic [7:0]  got, exp;
        logic [23:0] la;
        int          lat, nm;
        mem_wait = 0;
        do_read(24'h000000, got, lat, nm);
        exp = sb_q.pop_front();
        la  = mem_log[$];
        n_total++; if (got !== exp || got !== 8'hAA) $display("FAIL miss_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1) $display("FAIL miss_mem_count: got %0d want 1", nm); else n_pass++;
        n_total++; if (la !== 24'h100000) $display("FAIL miss_mem_addr: got %h want 100000", la); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL miss_latency: got %0d want 2", lat); else n_pass++;
        idle(6);
        for (int i = 1; i <= 3; i++) begin
            do_read(24'(i), got, lat, nm);
            exp = sb_q.pop_front();
            n_total++; if (got !== exp) $display("FAIL hit_data[%0d]: got %h want %h", i, got, exp); else n_pass++;
            n_total++; if (lat !== 1 || nm !== 0) $display("FAIL hit_timing[%0d]: got lat %0d mem %0d want lat 1 mem 0", i, lat, nm); else n_pass++;
            idle(1);
        end
    endtask

    task automatic test_alias();
        logic [7:0]  got, exp;
        logic [23:0] la;
        int          lat, nm;
        do_read(24'h000020, got, lat, nm);
        exp = sb_q.pop_front();
        la  = mem_log[$];
        n_total++; if (got !== exp) $display("FAIL alias_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1 || la !== 24'h100020) $display("FAIL alias_fetch: got mem %0d addr %h want 1 at 100020", nm, la); else n_pass++;
        idle(6);
        do_read(24'h000000, got, lat, nm);
        exp = sb_q.pop_front();
        la  = mem_log[$];
        n_total++; if (got !== exp) $display("FAIL alias_reread_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1 || la !== 24'h100000) $display("FAIL alias_reread_fetch: got mem %0d addr %h want 1 at 100000", nm, la); else n_pass++;
        idle(6);
    endtask

    task automatic test_inv_fetch();
        logic [7:0] got, exp;
        int         lat, nm;
        mem_wait = 5;
        fork
            do_read(24'h000040, got, lat, nm);
            begin
                idle(2);
                bus.inv = 1'b1;
                idle(1);
                bus.inv = 1'b0;
            end
        join
        exp = sb_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL inv_inflight_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1) $display("FAIL inv_inflight_fetch: got mem %0d want 1", nm); else n_pass++;
        idle(12);
        mem_wait = 0;
        do_read(24'h000040, got, lat, nm);
        exp = sb_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL inv_refetch_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1) $display("FAIL inv_refetch_count: got mem %0d want 1", nm); else n_pass++;
        idle(6);
    endtask

    task automatic test_stall();
        logic [7:0] got, exp;
        int         lat, nm;
        mem_wait = 50;
        fork
            do_read(24'h000080, got, lat, nm);
            for (int c = 0; c < 45; c++) begin
                @(negedge clk);
                n_total++;
                if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 24'h100080 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0)
                    $display("FAIL stall_hold[%0d]: got valid %b addr %h busy %b ready %b want 1 100080 1 0",
                             c, bus.mem_valid, bus.mem_addr, bus.busy, bus.req_ready);
                else n_pass++;
            end
        join
        exp = sb_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL stall_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (lat !== 52) $display("FAIL stall_latency: got %0d want 52", lat); else n_pass++;
        mem_wait = 0;
        idle(6);
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] got, exp;
        int         lat, nm;
        mem_wait = 20;
        bus.req_valid = 1'b1;
        bus.req_addr  = 24'h0000C0;
        idle(3);
        n_total++; if (bus.mem_valid !== 1'b1) $display("FAIL rstfetch_active: got %b want 1", bus.mem_valid); else n_pass++;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        idle(1);
        rst = 1'b0;
        test_reset();
        mem_wait = 0;
        idle(2);
        do_read(24'h000000, got, lat, nm);
        exp = sb_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL rstfetch_reread_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1) $display("FAIL rstfetch_reread_miss: got mem %0d want 1", nm); else n_pass++;
        idle(6);
    endtask

    task automatic test_prefetch();
        logic [7:0]  got, exp;
        logic [23:0] la;
        int          lat, nm;
        do_read(24'h000010, got, lat, nm);
        exp = sb_q.pop_front();
        la  = mem_log[$];
        n_total++; if (got !== exp) $display("FAIL pf_miss_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1 || la !== 24'h100010) $display("FAIL pf_miss_fetch: got mem %0d addr %h want 1 at 100010", nm, la); else n_pass++;
        idle(6);
`ifdef FLASH_CACHE_PREFETCH_EN
        la = mem_log[$];
        n_total++; if (la !== 24'h100014) $display("FAIL pf_addr: got %h want 100014", la); else n_pass++;
        do_read(24'h000014, got, lat, nm);
        exp = sb_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL pf_hit_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (lat !== 1 || nm !== 0) $display("FAIL pf_hit_timing: got lat %0d mem %0d want 1 0", lat, nm); else n_pass++;
`else
        do_read(24'h000014, got, lat, nm);
        exp = sb_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL nopf_data: got %h want %h", got, exp); else n_pass++;
        n_total++; if (nm !== 1) $display("FAIL nopf_miss: got mem %0d want 1", nm); else n_pass++;
`endif
        idle(6);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        int         lat, nm;
        for (int i = 0; i < 4; i++) begin
            do_read(24'h000010 + 24'(i), got, lat, nm);
            exp = sb_q.pop_front();
            n_total++; if (got !== exp) $display("FAIL b2b_data[%0d]: got %h want %h", i, got, exp); else n_pass++;
            n_total++;
            if (lat !== ((i == 0) ? 1 : 2) || nm !== 0)
                $display("FAIL b2b_timing[%0d]: got lat %0d mem %0d want lat %0d mem 0", i, lat, nm, (i == 0) ? 1 : 2);
            else n_pass++;
        end
        idle(2);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.inv       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        idle(3);
        rst = 1'b0;
        test_reset();
        test_miss_fill();
        test_alias();
        test_inv_fetch();
        test_stall();
        test_reset_mid_fetch();
        test_prefetch();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
